vga_pattern_sequencer: RTL and testbench

VGA_PATTERN_SEQUENCER -- requirements
Module: vga_pattern_sequencer

---
 rtl/vga_seq_pkg.sv | 13 +
 rtl/vga_seq_rr_next.sv | 24 ++
 rtl/vga_pattern_sequencer.sv | 174 +++++++++++++++++
 tb/tb_vga_pattern_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_seq_pkg.sv
// Shared types and constants for the VGA pattern sequencer.
// Holds the FSM state encoding and the reset dwell default.
package vga_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHOW   = 2'd1,
      ST_SWITCH = 2'd2
   } seq_state_t;

   localparam int SEQ_DEFAULT_DWELL = 60;

endpackage

// File: rtl/vga_seq_rr_next.sv
// Round-robin search: next set mask bit strictly above cur, wrapping.
// Returns cur itself when no other bit is set.
module vga_seq_rr_next #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] mask,
   input  logic [W-1:0] cur,
   output logic [W-1:0] nxt
);

   logic [W-1:0] idx;

   // Scan farthest offset first so the nearest set bit wins last.
   always_comb begin
      nxt = cur;
      idx = cur;
      for (int k = N; k >= 1; k--) begin
         idx = W'((int'(cur) + k) % N);
         if (mask[idx]) nxt = idx;
      end
   end

endmodule

// File: rtl/vga_pattern_sequencer.sv
// Frame-synchronous pattern sequencer with blanked switch frames.
// Optional macro VGA_SEQ_FREEZE_EN adds a freeze input.
module vga_pattern_sequencer
   import vga_seq_pkg::*;
#(
   parameter int NUM_PATTERNS  = 4,
   parameter int DWELL_W       = 8,
   parameter int DEFAULT_DWELL = SEQ_DEFAULT_DWELL
) (
   input  logic                            clk_25,
   input  logic                            rst,
`ifdef VGA_SEQ_FREEZE_EN
   input  logic                            freeze,
`endif
   input  logic                            vsync,
   input  logic                            cfg_valid,
   output logic                            cfg_ready,
   input  logic [DWELL_W-1:0]              cfg_dwell,
   input  logic [NUM_PATTERNS-1:0]         cfg_mask,
   output logic [$clog2(NUM_PATTERNS)-1:0] pattern_sel,
   output logic                            blank
);

   localparam int SEL_W = $clog2(NUM_PATTERNS);

   seq_state_t state, state_d;

   logic vsync_s, vsync_d, frame_tick;
   logic pend_valid;
   logic [DWELL_W-1:0] pend_dwell;
   logic [NUM_PATTERNS-1:0] pend_mask;
   logic [DWELL_W-1:0] dwell, frame_cnt, cnt_d, eff_last;
   logic [NUM_PATTERNS-1:0] mask;
   logic [SEL_W-1:0] sel_d, rr_sel, low_sel;
   logic blank_d, hold, apply, expire, has_other;

`ifdef VGA_SEQ_FREEZE_EN
   assign hold = freeze;
`else
   assign hold = 1'b0;
`endif

   vga_seq_rr_next #(.N(NUM_PATTERNS), .W(SEL_W)) u_rr (
      .mask (mask),
      .cur  (pattern_sel),
      .nxt  (rr_sel)
   );

   vga_seq_rr_next #(.N(NUM_PATTERNS), .W(SEL_W)) u_low (
      .mask (mask),
      .cur  (SEL_W'(NUM_PATTERNS - 1)),
      .nxt  (low_sel)
   );

   assign cfg_ready = ~pend_valid;
   assign apply     = frame_tick & pend_valid;
   assign eff_last  = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
   assign expire    = (frame_cnt == eff_last);
   assign has_other = (rr_sel != pattern_sel);

   // Sample vsync and emit a one-cycle tick per falling edge.
   always_ff @(posedge clk_25 or posedge rst) begin
      if (rst) begin
         vsync_s    <= 1'b1;
         vsync_d    <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         vsync_s    <= vsync;
         vsync_d    <= vsync_s;
         frame_tick <= vsync_d & ~vsync_s;
      end
   end

   // Single-entry pending config slot, emptied on the next tick.
   always_ff @(posedge clk_25 or posedge rst) begin
      if (rst) begin
         pend_valid <= 1'b0;
         pend_dwell <= '0;
         pend_mask  <= '0;
      end else if (cfg_valid && cfg_ready) begin
         pend_valid <= 1'b1;
         pend_dwell <= cfg_dwell;
         pend_mask  <= cfg_mask;
      end else if (apply) begin
         pend_valid <= 1'b0;
      end
   end

   // State, outputs and active config registers.
   always_ff @(posedge clk_25 or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         pattern_sel <= '0;
         blank       <= 1'b1;
         frame_cnt   <= '0;
         dwell       <= DWELL_W'(DEFAULT_DWELL);
         mask        <= '1;
      end else begin
         state       <= state_d;
         pattern_sel <= sel_d;
         blank       <= blank_d;
         frame_cnt   <= cnt_d;
         if (apply) begin
            dwell <= pend_dwell;
            mask  <= pend_mask;
         end
      end
   end

   // Next state: a config apply overrides any dwell expiry.
   always_comb begin
      state_d = state;
      if (apply) begin
         if (pend_mask == '0)
            state_d = ST_IDLE;
         else if (!pend_mask[pattern_sel])
            state_d = ST_SWITCH;
         else
            state_d = ST_SHOW;
      end else if (frame_tick) begin
         unique case (state)
            ST_IDLE:
               if (mask != '0) state_d = ST_SHOW;
            ST_SHOW:
               if (!hold && expire && has_other)
                  state_d = ST_SWITCH;
            ST_SWITCH:
               state_d = ST_SHOW;
            default:
               state_d = ST_IDLE;
         endcase
      end
   end

   // Next output values, committed only on a frame tick.
   always_comb begin
      sel_d   = pattern_sel;
      blank_d = blank;
      cnt_d   = frame_cnt;
      if (apply) begin
         cnt_d   = '0;
         blank_d = (state_d != ST_SHOW);
      end else if (frame_tick) begin
         unique case (state)
            ST_IDLE: begin
               if (mask != '0) begin
                  sel_d   = low_sel;
                  cnt_d   = '0;
                  blank_d = 1'b0;
               end
            end
            ST_SHOW: begin
               if (!hold) begin
                  if (expire) begin
                     cnt_d   = '0;
                     blank_d = has_other;
                  end else begin
                     cnt_d = frame_cnt + DWELL_W'(1);
                  end
               end
            end
            ST_SWITCH: begin
               sel_d   = rr_sel;
               cnt_d   = '0;
               blank_d = 1'b0;
            end
            default: begin
               blank_d = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Directed self-checking bench for vga_pattern_sequencer.
// Freeze steps are built only with VGA_SEQ_FREEZE_EN.
module tb_vga_pattern_sequencer;

   logic       clk_25 = 1'b0;
   logic       rst;
   logic       vsync;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [7:0] cfg_dwell;
   logic [3:0] cfg_mask;
   logic [1:0] pattern_sel;
   logic       blank;
`ifdef VGA_SEQ_FREEZE_EN
   logic       freeze;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   vga_pattern_sequencer dut (
      .clk_25      (clk_25),
      .rst         (rst),
`ifdef VGA_SEQ_FREEZE_EN
      .freeze      (freeze),
`endif
      .vsync       (vsync),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_dwell   (cfg_dwell),
      .cfg_mask    (cfg_mask),
      .pattern_sel (pattern_sel),
      .blank       (blank)
   );

   always #5 clk_25 = ~clk_25;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // One vsync low pulse; returns at a negedge after outputs settle.
   task automatic frame();
      @(negedge clk_25);
      vsync = 1'b0;
      repeat (2) @(negedge clk_25);
      vsync = 1'b1;
      repeat (4) @(negedge clk_25);
   endtask

   task automatic send(input logic [3:0] m, input logic [7:0] d);
      @(negedge clk_25);
      chk("ready_before_send", cfg_ready, 1);
      cfg_valid = 1'b1;
      cfg_mask  = m;
      cfg_dwell = d;
      @(negedge clk_25);
      cfg_valid = 1'b0;
      chk("ready_after_send", cfg_ready, 0);
   endtask

   task automatic out(input string tag,
                      input logic [1:0] s,
                      input logic b);
      chk({tag, "_sel"}, pattern_sel, s);
      chk({tag, "_blank"}, blank, b);
   endtask

   initial begin
      rst = 1'b1;
      vsync = 1'b1;
      cfg_valid = 1'b0;
      cfg_mask = '0;
      cfg_dwell = '0;
`ifdef VGA_SEQ_FREEZE_EN
      freeze = 1'b0;
`endif
      repeat (3) @(negedge clk_25);
      out("reset", 2'd0, 1'b1);
      chk("reset_ready", cfg_ready, 1);
      rst = 1'b0;
      repeat (3) @(negedge clk_25);
      out("idle_no_tick", 2'd0, 1'b1);

      // Full rotation with dwell 2.
      send(4'b1111, 8'd2);
      frame();
      chk("ready_after_apply", cfg_ready, 1);
      for (int k = 0; k < 4; k++) begin
         out("rot_show_a", 2'(k), 1'b0);
         frame();
         out("rot_show_b", 2'(k), 1'b0);
         frame();
         out("rot_switch", 2'(k), 1'b1);
         frame();
      end
      out("rot_wrap", 2'd0, 1'b0);

      // Single-bit mask: no switch frames.
      send(4'b0100, 8'd2);
      frame();
      out("single_apply", 2'd0, 1'b1);
      frame();
      out("single_enter", 2'd2, 1'b0);
      for (int k = 0; k < 5; k++) begin
         frame();
         out("single_hold", 2'd2, 1'b0);
      end

      // Move to 1, then mask 1001 while showing 1.
      send(4'b0010, 8'd2);
      frame();
      frame();
      out("show_one", 2'd1, 1'b0);
      send(4'b1001, 8'd2);
      frame();
      out("drop_one_blank", 2'd1, 1'b1);
      frame();
      out("drop_one_next", 2'd3, 1'b0);

      // Empty mask goes idle, then re-enable bit 1.
      send(4'b0000, 8'd2);
      frame();
      out("idle_enter", 2'd3, 1'b1);
      frame();
      out("idle_stay", 2'd3, 1'b1);
      send(4'b0010, 8'd2);
      frame();
      out("idle_exit_blank", 2'd3, 1'b1);
      frame();
      out("idle_exit_show", 2'd1, 1'b0);

      // Dwell 0 behaves as 1 frame.
      send(4'b0011, 8'd0);
      frame();
      out("dw0_apply", 2'd1, 1'b0);
      frame();
      out("dw0_switch", 2'd1, 1'b1);
      frame();
      out("dw0_wrap", 2'd0, 1'b0);
      frame();
      out("dw0_switch2", 2'd0, 1'b1);
      frame();
      out("dw0_show1", 2'd1, 1'b0);

      // Apply and expiry on one tick: apply wins.
      send(4'b0011, 8'd3);
      frame();
      out("prec_apply", 2'd1, 1'b0);
      frame();
      out("prec_cnt1", 2'd1, 1'b0);
      frame();
      out("prec_cnt2", 2'd1, 1'b0);
      frame();
      out("prec_expire", 2'd1, 1'b1);
      frame();
      out("prec_next", 2'd0, 1'b0);

      // Held cfg_valid with a second request queued.
      @(negedge clk_25);
      cfg_valid = 1'b1;
      cfg_mask  = 4'b1100;
      cfg_dwell = 8'd2;
      @(negedge clk_25);
      chk("q_ready_low", cfg_ready, 0);
      cfg_mask  = 4'b0110;
      repeat (3) @(negedge clk_25);
      chk("q_ignored_ready", cfg_ready, 0);
      out("q_no_early_apply", 2'd0, 1'b0);
      frame();
      chk("q_second_taken", cfg_ready, 0);
      out("q_tick1", 2'd0, 1'b1);
      cfg_valid = 1'b0;
      frame();
      chk("q_ready_back", cfg_ready, 1);
      out("q_tick2", 2'd0, 1'b1);
      frame();
      out("q_tick3", 2'd1, 1'b0);

      // Async reset discards a pending config.
      send(4'b1111, 8'd2);
      #2 rst = 1'b1;
      #1;
      out("async_rst", 2'd0, 1'b1);
      chk("async_rst_ready", cfg_ready, 1);
      @(negedge clk_25);
      rst = 1'b0;
      frame();
      out("post_rst_t1", 2'd0, 1'b0);
      frame();
      frame();
      out("post_rst_t3", 2'd0, 1'b0);

`ifdef VGA_SEQ_FREEZE_EN
      send(4'b1111, 8'd2);
      frame();
      out("frz_apply", 2'd0, 1'b0);
      freeze = 1'b1;
      for (int k = 0; k < 5; k++) begin
         frame();
         out("frz_hold", 2'd0, 1'b0);
      end
      freeze = 1'b0;
      frame();
      out("frz_rel1", 2'd0, 1'b0);
      frame();
      out("frz_rel2", 2'd0, 1'b1);
      frame();
      out("frz_next", 2'd1, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
